// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge controller.
package ahb2apb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Default APB address window: four 64 MiB slots starting at 0x8000_0000
  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR  = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] DEF_SLAVE_SPAN = 32'h0400_0000;
  localparam int unsigned       DEF_NUM_SLAVES = 4;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  // Burst encodings; bursts are split into independent APB beats, so these are informational
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_WSETUP,
    ST_WENABLE,
    ST_RSETUP,
    ST_RENABLE,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

endpackage

// File: rtl/ahb2apb_addr_decode.sv
// Address-phase decoder: qualifies an AHB transfer and maps its address to a one-hot APB slave select.
module ahb2apb_addr_decode
  import ahb2apb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] SLAVE_SPAN = DEF_SLAVE_SPAN,
  parameter int unsigned       NUM_SLAVES = DEF_NUM_SLAVES
) (
  input  logic                  Hreadyin,
  input  logic [1:0]            Htrans,
  input  logic [ADDR_W-1:0]     Haddr,
  output logic                  valid_c,
  output logic                  err_c,
  output logic [NUM_SLAVES-1:0] sel_c
);

  // Window arithmetic carried at 33 bits so the top of the window cannot wrap
  localparam logic [ADDR_W:0] SPAN_X = {1'b0, SLAVE_SPAN};
  localparam logic [ADDR_W:0] WINDOW = 33'(NUM_SLAVES) * SPAN_X;

  logic            active_c;
  logic            in_win_c;
  logic [ADDR_W:0] off_c;

  // Qualify the transfer and pick the slot the offset falls into
  always_comb begin
    active_c = Hreadyin && ((Htrans == HT_NONSEQ) || (Htrans == HT_SEQ));
    off_c    = {1'b0, Haddr} - {1'b0, BASE_ADDR};
    in_win_c = (Haddr >= BASE_ADDR) && (off_c < WINDOW);
    valid_c  = active_c && in_win_c;
    err_c    = active_c && !in_win_c;
    sel_c    = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      sel_c[i] = in_win_c && (off_c >= 33'(i) * SPAN_X) && (off_c < 33'(i + 1) * SPAN_X);
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_ctrl.sv
// AHB slave / APB master bridge controller: one APB SETUP+ENABLE pair per accepted AHB beat.
// Optional feature macro AHB2APB_ERR_RESP_EN: out-of-window transfers get a two-cycle ERROR response.
module ahb2apb_bridge_ctrl
  import ahb2apb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [ADDR_W-1:0] SLAVE_SPAN = DEF_SLAVE_SPAN,
  parameter int unsigned       NUM_SLAVES = DEF_NUM_SLAVES
) (
  input  logic                  clk,
  input  logic                  Hrst,
  input  logic                  Hwrite,
  input  logic                  Hreadyin,
  input  logic [1:0]            Htrans,
  input  logic [2:0]            Hsize,
  input  logic [ADDR_W-1:0]     Haddr,
  input  logic [DATA_W-1:0]     Hwdata,
  output logic                  Hreadyout,
  output logic [1:0]            Hresp,
  output logic [DATA_W-1:0]     Hrdata,
  input  logic [DATA_W-1:0]     Prdata,
  output logic [ADDR_W-1:0]     Paddr,
  output logic [DATA_W-1:0]     Pwdata,
  output logic                  Pwrite,
  output logic [NUM_SLAVES-1:0] Pselx,
  output logic                  Penable
);

  bridge_state_t         state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0] pselx_q, pselx_d;
  logic                  penable_q, penable_d;

  logic                  valid_c;
  logic                  err_c;
  logic [NUM_SLAVES-1:0] sel_c;
  logic                  unused_c;

  ahb2apb_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .SLAVE_SPAN (SLAVE_SPAN),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .Hreadyin (Hreadyin),
    .Htrans   (Htrans),
    .Haddr    (Haddr),
    .valid_c  (valid_c),
    .err_c    (err_c),
    .sel_c    (sel_c)
  );

  // Transfer size is accepted but has no effect on the APB side
`ifdef AHB2APB_ERR_RESP_EN
  assign unused_c = ^Hsize;
`else
  assign unused_c = ^{Hsize, err_c};
`endif

  // State and APB output registers
  always_ff @(posedge clk) begin
    if (Hrst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
    end
  end

  // Next state, address-phase capture, and APB outputs derived from the upcoming state
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    sel_d     = sel_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    pselx_d   = '0;
    penable_d = 1'b0;

    case (state_q)
      ST_WWAIT: begin
        pwdata_d = Hwdata;
        state_d  = ST_WSETUP;
      end
      ST_WSETUP: state_d = ST_WENABLE;
      ST_RSETUP: state_d = ST_RENABLE;
      ST_ERR1:   state_d = ST_ERR2;
      // Hreadyout is high in these states, so a new address phase is sampled
      ST_IDLE, ST_WENABLE, ST_RENABLE, ST_ERR2: begin
        if (valid_c) begin
          addr_d  = Haddr;
          write_d = Hwrite;
          sel_d   = sel_c;
          state_d = Hwrite ? ST_WWAIT : ST_RSETUP;
        end
`ifdef AHB2APB_ERR_RESP_EN
        else if (err_c) begin
          state_d = ST_ERR1;
        end
`endif
        else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reads enter SETUP straight from the address phase, writes via the captured pipeline
    case (state_d)
      ST_WSETUP: begin
        paddr_d  = addr_q;
        pwrite_d = write_q;
        pselx_d  = sel_q;
      end
      ST_RSETUP: begin
        paddr_d  = Haddr;
        pwrite_d = 1'b0;
        pselx_d  = sel_c;
      end
      ST_WENABLE, ST_RENABLE: begin
        pselx_d   = pselx_q;
        penable_d = 1'b1;
      end
      default: ;
    endcase
  end

  // AHB-side responses decoded from the registered state
  always_comb begin
    Hreadyout = !((state_q == ST_WWAIT) || (state_q == ST_WSETUP) ||
                  (state_q == ST_RSETUP) || (state_q == ST_ERR1));
    Hrdata    = (state_q == ST_RENABLE) ? Prdata : '0;
  end

`ifdef AHB2APB_ERR_RESP_EN
  assign Hresp = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign Hresp = HRESP_OKAY;
`endif

  assign Paddr   = paddr_q;
  assign Pwdata  = pwdata_q;
  assign Pwrite  = pwrite_q;
  assign Pselx   = pselx_q;
  assign Penable = penable_q;

endmodule
